// File: rtl/picobello_offload_arbiter_if.sv
// Handshake bundle between the router reduction ports, the arbiter and the offload unit.
// slave is the arbiter's view; master is the view of the surrounding requesters and unit.
interface picobello_offload_arbiter_if #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned OpWidth   = 4
);
    logic [NumReq-1:0]             req_valid_i;
    logic [NumReq-1:0]             req_ready_o;
    logic [NumReq*2*DataWidth-1:0] req_operands_i;
    logic [NumReq*OpWidth-1:0]     req_op_i;
    logic [NumReq-1:0]             rsp_valid_o;
    logic [NumReq-1:0]             rsp_ready_i;
    logic [DataWidth-1:0]          rsp_result_o;
    logic                          offload_req_valid_o;
    logic                          offload_req_ready_i;
    logic [2*DataWidth-1:0]        offload_req_operands_o;
    logic [OpWidth-1:0]            offload_req_operation_o;
    logic                          offload_rsp_valid_i;
    logic                          offload_rsp_ready_o;
    logic [DataWidth-1:0]          offload_rsp_result_i;

    modport slave (
        input  req_valid_i, req_operands_i, req_op_i, rsp_ready_i,
               offload_req_ready_i, offload_rsp_valid_i, offload_rsp_result_i,
        output req_ready_o, rsp_valid_o, rsp_result_o,
               offload_req_valid_o, offload_req_operands_o, offload_req_operation_o,
               offload_rsp_ready_o
    );

    modport master (
        output req_valid_i, req_operands_i, req_op_i, rsp_ready_i,
               offload_req_ready_i, offload_rsp_valid_i, offload_rsp_result_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o,
               offload_req_valid_o, offload_req_operands_o, offload_req_operation_o,
               offload_rsp_ready_o
    );
endinterface

// File: rtl/picobello_offload_arbiter.sv
// Round-robin sharing of one in-order offload reduction unit; an ID FIFO routes results back.
// Optional perf counters are built when PICOBELLO_OFFLOAD_ARB_PERF_EN is defined.
module picobello_offload_arbiter #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned OpWidth        = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    picobello_offload_arbiter_if.slave bus,
    output logic        busy_o,
    output logic        err_o,
    output logic [31:0] perf_ops_o,
    output logic [31:0] perf_stall_o
);
    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned PtrW = $clog2(MaxOutstanding);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

    lock_state_e     state_reg, state_next;
    logic [IdxW-1:0] lock_idx_reg, lock_idx_next;
    logic [IdxW-1:0] rr_ptr_reg;
    logic            err_reg;
    logic [PtrW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CntW-1:0] count_reg;
    // Asynchronous read keeps the response path at zero latency (small distributed RAM).
    logic [IdxW-1:0] id_mem [MaxOutstanding];

    logic [2*DataWidth-1:0] operands_arr [NumReq];
    logic [OpWidth-1:0]     op_arr [NumReq];

    logic            any_valid, full, empty, lock_drop;
    logic            req_fire_valid, req_hs, rsp_hs, spurious;
    logic [IdxW-1:0] winner, head;

    assign any_valid = |bus.req_valid_i;
    assign full      = (count_reg == CntW'(MaxOutstanding));
    assign empty     = (count_reg == '0);
    assign head      = id_mem[rd_ptr_reg];
    // A locked requester that withdraws is flagged and never forwarded to the unit.
    assign lock_drop = (state_reg == LOCKED) && !bus.req_valid_i[lock_idx_reg];

    always_comb begin
        int  cand;
        logic found;
        cand   = 0;
        found  = 1'b0;
        winner = '0;
        if (state_reg == LOCKED) begin
            winner = lock_idx_reg;
        end else begin
            for (int k = 0; k < int'(NumReq); k++) begin
                cand = (int'(rr_ptr_reg) + k) % int'(NumReq);
                if (!found && bus.req_valid_i[cand]) begin
                    winner = IdxW'(cand);
                    found  = 1'b1;
                end
            end
        end
    end

    assign req_fire_valid = any_valid && !full && !lock_drop && !rst_i;
    assign req_hs         = req_fire_valid && bus.offload_req_ready_i;
    assign spurious       = bus.offload_rsp_valid_i && empty;

    assign bus.offload_req_valid_o     = req_fire_valid;
    assign bus.offload_req_operands_o  = operands_arr[winner];
    assign bus.offload_req_operation_o = op_arr[winner];
    assign bus.offload_rsp_ready_o     = !empty && !rst_i && bus.rsp_ready_i[head];
    assign bus.rsp_result_o            = bus.offload_rsp_result_i;
    assign rsp_hs = bus.offload_rsp_valid_i && bus.offload_rsp_ready_o;

    generate
        for (genvar gi = 0; gi < int'(NumReq); gi++) begin : g_req
            assign operands_arr[gi] = bus.req_operands_i[gi*2*DataWidth +: 2*DataWidth];
            assign op_arr[gi]       = bus.req_op_i[gi*OpWidth +: OpWidth];
            assign bus.req_ready_o[gi] = (winner == IdxW'(gi)) && bus.offload_req_ready_i
                                         && !full && !rst_i;
            assign bus.rsp_valid_o[gi] = (head == IdxW'(gi)) && bus.offload_rsp_valid_i
                                         && !empty && !rst_i;
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        lock_idx_next = lock_idx_reg;
        case (state_reg)
            UNLOCKED: begin
                if (req_fire_valid && !bus.offload_req_ready_i) begin
                    state_next    = LOCKED;
                    lock_idx_next = winner;
                end
            end
            LOCKED: begin
                if (lock_drop || req_hs) state_next = UNLOCKED;
            end
            default: state_next = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= UNLOCKED;
            lock_idx_reg <= '0;
            rr_ptr_reg   <= '0;
            err_reg      <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            lock_idx_reg <= lock_idx_next;
            if (req_hs) begin
                rr_ptr_reg <= (winner == IdxW'(NumReq - 1)) ? '0 : winner + 1'b1;
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rsp_hs) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (req_hs && !rsp_hs) count_reg <= count_reg + 1'b1;
            else if (!req_hs && rsp_hs) count_reg <= count_reg - 1'b1;
            if (lock_drop || spurious) err_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_hs) id_mem[wr_ptr_reg] <= winner;
    end

    assign busy_o = !empty;
    assign err_o  = err_reg;

`ifdef PICOBELLO_OFFLOAD_ARB_PERF_EN
    logic [31:0] perf_ops_reg, perf_stall_reg;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_ops_reg   <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (req_hs && perf_ops_reg != '1) perf_ops_reg <= perf_ops_reg + 1'b1;
            if (any_valid && !req_hs && perf_stall_reg != '1)
                perf_stall_reg <= perf_stall_reg + 1'b1;
        end
    end
    assign perf_ops_o   = perf_ops_reg;
    assign perf_stall_o = perf_stall_reg;
`else
    assign perf_ops_o   = '0;
    assign perf_stall_o = '0;
`endif
endmodule

// File: tb/tb_picobello_offload_arbiter.sv
// Directed bench for picobello_offload_arbiter: arbitration, lock, ID FIFO routing, errors, reset.
module tb_picobello_offload_arbiter;
    localparam int unsigned NumReq = 2;
    localparam int unsigned MaxOut = 4;
    localparam int unsigned DW     = 64;
    localparam int unsigned OW     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy, err;
    logic [31:0] perf_ops, perf_stall;
    int          tests_run = 0;
    int          tests_failed = 0;

    localparam logic [63:0] F2 = 64'h4000000000000000;
    localparam logic [63:0] F3 = 64'h4008000000000000;
    localparam logic [63:0] F5 = 64'h4014000000000000;
    localparam logic [127:0] OPS0 = {F2, F3};
    localparam logic [127:0] OPS1 = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};

    picobello_offload_arbiter_if #(.NumReq(NumReq), .DataWidth(DW), .OpWidth(OW)) bus ();

    picobello_offload_arbiter #(
        .NumReq(NumReq), .MaxOutstanding(MaxOut), .DataWidth(DW), .OpWidth(OW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .busy_o(busy), .err_o(err), .perf_ops_o(perf_ops), .perf_stall_o(perf_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid_i          = '0;
        bus.rsp_ready_i          = '0;
        bus.offload_req_ready_i  = 1'b0;
        bus.offload_rsp_valid_i  = 1'b0;
        bus.offload_rsp_result_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [1:0] exp_grant [4];
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
        clear_inputs();
        bus.req_operands_i = {OPS1, OPS0};
        bus.req_op_i       = {4'd7, 4'd4};

        // Outputs held quiet while reset is asserted, even with active inputs.
        bus.req_valid_i = 2'b11;
        bus.offload_req_ready_i = 1'b1;
        bus.offload_rsp_valid_i = 1'b1;
        bus.rsp_ready_i = 2'b11;
        #2;
        check("rst_off_req_valid", bus.offload_req_valid_o, 0);
        check("rst_req_ready", bus.req_ready_o, 0);
        check("rst_rsp_valid", bus.rsp_valid_o, 0);
        check("rst_off_rsp_ready", bus.offload_rsp_ready_o, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_perf_ops", perf_ops, 0);
        @(posedge clk);
        #1;
        do_reset();

        // Single F_Add from requester 0.
        bus.req_valid_i = 2'b01;
        bus.offload_req_ready_i = 1'b1;
        #1;
        check("t1_req_ready", bus.req_ready_o, 2'b01);
        check("t1_off_valid", bus.offload_req_valid_o, 1);
        check("t1_op", bus.offload_req_operation_o, 4);
        check("t1_operands", bus.offload_req_operands_o, OPS0);
        tick();
        bus.req_valid_i = 2'b00;
        #1;
        check("t1_busy", busy, 1);
        bus.offload_rsp_valid_i = 1'b1;
        bus.offload_rsp_result_i = F5;
        bus.rsp_ready_i = 2'b11;
        #1;
        check("t1_rsp_valid", bus.rsp_valid_o, 2'b01);
        check("t1_off_rsp_ready", bus.offload_rsp_ready_o, 1);
        check("t1_result", bus.rsp_result_o, F5);
        tick();
        bus.offload_rsp_valid_i = 1'b0;
        #1;
        check("t1_busy_after", busy, 0);
        check("t1_err", err, 0);

        // Both requesters continuously valid: alternating grants, then full.
        do_reset();
        bus.req_valid_i = 2'b11;
        bus.offload_req_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_grant%0d", i), bus.req_ready_o, exp_grant[i]);
            check($sformatf("rr_op%0d", i), bus.offload_req_operation_o, (i % 2 == 0) ? 4 : 7);
            tick();
        end
        #1;
        check("full_off_valid", bus.offload_req_valid_o, 0);
        check("full_req_ready", bus.req_ready_o, 0);
        check("full_busy", busy, 1);
        bus.req_valid_i = 2'b00;
        bus.offload_rsp_valid_i = 1'b1;
        bus.rsp_ready_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            bus.offload_rsp_result_i = 64'(i + 100);
            #1;
            check($sformatf("order_rsp%0d", i), bus.rsp_valid_o, exp_grant[i]);
            tick();
        end
        bus.offload_rsp_valid_i = 1'b0;
        #1;
        check("order_busy_end", busy, 0);

        // Full FIFO is not bypassed by a same-cycle pop.
        do_reset();
        bus.req_valid_i = 2'b01;
        bus.offload_req_ready_i = 1'b1;
        repeat (4) tick();
        bus.offload_rsp_valid_i = 1'b1;
        bus.rsp_ready_i = 2'b11;
        #1;
        check("nobypass_off_valid", bus.offload_req_valid_o, 0);
        check("nobypass_req_ready", bus.req_ready_o, 0);
        check("nobypass_rsp_valid", bus.rsp_valid_o, 2'b01);
        tick();
        bus.offload_rsp_valid_i = 1'b0;
        #1;
        check("after_pop_req_ready", bus.req_ready_o, 2'b01);
        check("after_pop_off_valid", bus.offload_req_valid_o, 1);
        tick();
        bus.req_valid_i = 2'b00;
        bus.offload_rsp_valid_i = 1'b1;
        repeat (4) tick();
        bus.offload_rsp_valid_i = 1'b0;
        #1;
        check("nobypass_drained", busy, 0);

        // Grant locked on requester 1 while the unit stalls.
        do_reset();
        bus.req_valid_i = 2'b10;
        #1;
        check("lock_c0_req_ready", bus.req_ready_o, 0);
        check("lock_c0_off_valid", bus.offload_req_valid_o, 1);
        check("lock_c0_operands", bus.offload_req_operands_o, OPS1);
        tick();
        bus.req_valid_i = 2'b11;
        for (int i = 1; i < 3; i++) begin
            #1;
            check($sformatf("lock_c%0d_operands", i), bus.offload_req_operands_o, OPS1);
            check($sformatf("lock_c%0d_op", i), bus.offload_req_operation_o, 7);
            tick();
        end
        bus.offload_req_ready_i = 1'b1;
        #1;
        check("lock_hs_req_ready", bus.req_ready_o, 2'b10);
        tick();
        #1;
        check("lock_next_req_ready", bus.req_ready_o, 2'b01);
        tick();
        bus.req_valid_i = 2'b00;

        // Head = 1 waits on its requester's ready.
        bus.offload_rsp_valid_i = 1'b1;
        bus.offload_rsp_result_i = 64'hABCD;
        bus.rsp_ready_i = 2'b01;
        #1;
        check("hold_off_rsp_ready", bus.offload_rsp_ready_o, 0);
        check("hold_rsp_valid", bus.rsp_valid_o, 2'b10);
        check("hold_result", bus.rsp_result_o, 64'hABCD);
        tick();
        check("hold2_rsp_valid", bus.rsp_valid_o, 2'b10);
        bus.rsp_ready_i = 2'b11;
        #1;
        check("hold_release_ready", bus.offload_rsp_ready_o, 1);
        tick();
        check("hold_next_head", bus.rsp_valid_o, 2'b01);
        tick();
        bus.offload_rsp_valid_i = 1'b0;
        #1;
        check("hold_busy_end", busy, 0);

        // Locked requester withdraws: flagged, nothing forwarded.
        do_reset();
        bus.req_valid_i = 2'b10;
        tick();
        bus.req_valid_i = 2'b01;
        #1;
        check("drop_off_valid", bus.offload_req_valid_o, 0);
        tick();
        check("drop_err", err, 1);
        check("drop_busy", busy, 0);
        bus.offload_req_ready_i = 1'b1;
        #1;
        check("drop_unlocked_grant", bus.req_ready_o, 2'b01);

        // Spurious response sets a sticky error; reset clears everything.
        do_reset();
        check("spur_err_pre", err, 0);
        bus.offload_rsp_valid_i = 1'b1;
        bus.rsp_ready_i = 2'b11;
        #1;
        check("spur_off_rsp_ready", bus.offload_rsp_ready_o, 0);
        check("spur_rsp_valid", bus.rsp_valid_o, 0);
        tick();
        bus.offload_rsp_valid_i = 1'b0;
        #1;
        check("spur_err", err, 1);
        tick();
        check("spur_err_sticky", err, 1);
        bus.req_valid_i = 2'b01;
        bus.offload_req_ready_i = 1'b1;
        tick();
        tick();
        bus.req_valid_i = 2'b00;
        #1;
        check("inflight_busy", busy, 1);
`ifdef PICOBELLO_OFFLOAD_ARB_PERF_EN
        check("inflight_perf_ops", perf_ops, 2);
`endif
        rst = 1'b1;
        #1;
        check("rst2_busy", busy, 0);
        check("rst2_err", err, 0);
        check("rst2_perf_ops", perf_ops, 0);
        rst = 1'b0;
        #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
